// File: rtl/dewhiten_sequencer.sv
// Packet controller for the serial dewhitener: bit tick, sync hunt, seed load, length/CRC sequencing.
// Seed load 1 clk after sync match, trigger 1 clk after seed; no backpressure, enable low aborts.
module dewhiten_sequencer #(
    parameter int          BIT_PERIOD = 50,
    parameter logic [31:0] SYNC_WORD  = 32'h8E89BED6,
    parameter int          MAX_LEN    = 37,
    parameter int          CRC_BITS   = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       raw_bit,
    input  logic [5:0] channel,
    input  logic       dw_bit,
    output logic       bit_tick,
    output logic       dw_trigger,
    output logic       dw_seed_load,
    output logic [6:0] dw_seed,
    output logic       pdu_bit,
    output logic       pdu_valid,
    output logic [7:0] pkt_len,
    output logic       busy,
    output logic       pkt_done,
    output logic       len_err
);
    localparam int CW = $clog2(BIT_PERIOD);

    typedef enum logic [2:0] {IDLE, HUNT, SEED, HEADER, PAYLOAD, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   period_cnt;
    logic [31:0]     sync_sr, sync_next;
    logic [10:0]     bit_cnt;
    logic [7:0]      len_sr, len_next;
    logic            err_q;
    logic            in_pkt, capture, hdr_last, len_bad;

    assign sync_next = {raw_bit, sync_sr[31:1]};
    assign len_next  = {dw_bit, len_sr[7:1]};
    assign in_pkt    = (state == HEADER) || (state == PAYLOAD);
    // dw_bit is valid on the cycle after the tick, i.e. counter value 1
    assign capture   = in_pkt && (period_cnt == CW'(1));
    assign hdr_last  = capture && (state == HEADER) && (bit_cnt == 11'd15);
    assign len_bad   = len_next > 8'(MAX_LEN);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state != IDLE && !enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) next_state = HUNT;
                HUNT:    if (bit_tick && sync_next == SYNC_WORD) next_state = SEED;
                SEED:    next_state = HEADER;
                HEADER:  if (hdr_last) next_state = len_bad ? DONE : PAYLOAD;
                PAYLOAD: if (capture && bit_cnt == 11'd1) next_state = DONE;
                DONE:    next_state = HUNT;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_tick     = (state != IDLE) && (period_cnt == '0);
        dw_trigger   = in_pkt;
        dw_seed_load = (state == SEED);
        dw_seed      = (state == SEED) ? {channel, 1'b1} : 7'd0;
        pdu_valid    = capture;
        pdu_bit      = capture & dw_bit;
        busy         = (state == SEED) || in_pkt;
        pkt_done     = (state == DONE) && !err_q;
        len_err      = (state == DONE) && err_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_cnt <= '0;
            sync_sr    <= '0;
            bit_cnt    <= '0;
            len_sr     <= '0;
            pkt_len    <= '0;
            err_q      <= 1'b0;
        end else begin
            // Zeroing in SEED aligns the first header tick with the first trigger cycle
            if (state == IDLE || state == SEED || next_state == IDLE)
                period_cnt <= '0;
            else if (period_cnt == CW'(BIT_PERIOD - 1))
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 1'b1;

            if (state == HUNT && bit_tick)
                sync_sr <= sync_next;
            else if (state == DONE || state == IDLE)
                sync_sr <= '0;

            if (state == SEED) begin
                bit_cnt <= '0;
                err_q   <= 1'b0;
            end else if (capture && enable) begin
                if (state == HEADER) begin
                    if (bit_cnt[3]) len_sr <= len_next;
                    if (bit_cnt == 11'd15) begin
                        pkt_len <= len_next;
                        err_q   <= len_bad;
                        bit_cnt <= {len_next, 3'b000} + 11'(CRC_BITS);
                    end else begin
                        bit_cnt <= bit_cnt + 11'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt - 11'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dewhiten_sequencer.sv
// Directed bench for dewhiten_sequencer: queue scoreboard of dewhitened bits plus packet-level checks.
module tb_dewhiten_sequencer;
    logic        clock = 1'b0;
    logic        reset, enable, raw_bit, dw_bit;
    logic [5:0]  channel;
    logic        bit_tick, dw_trigger, dw_seed_load, pdu_bit, pdu_valid, busy, pkt_done, len_err;
    logic [6:0]  dw_seed;
    logic [7:0]  pkt_len;

    logic [31:0] sw = 32'h8E89BED6;
    int checks = 0, errors = 0, cycle = 0;
    bit raw_q[$], tx_q[$], exp_q[$];
    int n_valid, done_cnt, err_cnt, seed_cnt, trig_seen;
    int last_valid_cyc, seed_cyc;
    logic trig_prev = 1'b0;

    dewhiten_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .raw_bit(raw_bit), .channel(channel),
        .dw_bit(dw_bit), .bit_tick(bit_tick), .dw_trigger(dw_trigger), .dw_seed_load(dw_seed_load),
        .dw_seed(dw_seed), .pdu_bit(pdu_bit), .pdu_valid(pdu_valid), .pkt_len(pkt_len), .busy(busy),
        .pkt_done(pkt_done), .len_err(len_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, score them, then drive the next inputs.
    task automatic cyc();
        @(negedge clock);
        cycle++;
        if (pdu_valid) begin
            check("pdu_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("pdu_bit", 32'(pdu_bit), 32'(exp_q.pop_front()));
            if (n_valid > 0) check("pdu_spacing", cycle - last_valid_cyc, 32'd50);
            else             check("pdu_first", cycle - seed_cyc, 32'd2);
            n_valid++;
            last_valid_cyc = cycle;
        end
        if (dw_seed_load) begin
            seed_cnt++;
            seed_cyc = cycle;
            check("seed", 32'(dw_seed), 32'({channel, 1'b1}));
        end
        if (dw_trigger && !trig_prev) begin
            trig_seen++;
            check("trig_after_seed", cycle - seed_cyc, 32'd1);
        end
        if (pkt_done) begin
            done_cnt++;
            check("done_latency", cycle - last_valid_cyc, 32'd1);
            check("done_trig", 32'(dw_trigger), 32'd0);
        end
        if (len_err) err_cnt++;
        trig_prev = dw_trigger;
        if (bit_tick && !busy) raw_bit = (raw_q.size() > 0) ? raw_q.pop_front() : 1'b0;
        if (bit_tick && dw_trigger) begin
            dw_bit = (tx_q.size() > 0) ? tx_q.pop_front() : 1'($urandom_range(0, 1));
            exp_q.push_back(dw_bit);
        end
    endtask

    task automatic start_pkt(input logic [7:0] len, input logic [31:0] sync);
        logic [7:0] hdr0;
        hdr0 = 8'($urandom);
        n_valid = 0; done_cnt = 0; err_cnt = 0; seed_cnt = 0; trig_seen = 0;
        exp_q.delete(); tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(hdr0[i]);
        for (int i = 0; i < 8; i++) tx_q.push_back(len[i]);
        for (int i = 0; i < int'(len) * 8 + 24; i++) tx_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) raw_q.push_back(sync[i]);
    endtask

    task automatic run_pkt(input logic [7:0] len);
        int n, budget;
        n = 0;
        budget = (32 + 16 + int'(len) * 8 + 24 + 20) * 50;
        do begin
            cyc();
            n++;
        end while (!pkt_done && !len_err && n < budget);
        check("pkt_end_seen", 32'(pkt_done || len_err), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; raw_bit = 1'b0; dw_bit = 1'b0; channel = 6'd37;

        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_outputs", 32'({bit_tick, dw_trigger, dw_seed_load, dw_seed, pdu_bit,
                                        pdu_valid, pkt_len, busy, pkt_done, len_err}), 32'd0);
        end
        reset = 1'b0;
        #1 check("tick_at_release", 32'(bit_tick), 32'd0);
        cyc();
        check("tick_after_release", 32'(bit_tick), 32'd1);
        n = 0;
        do begin cyc(); n++; end while (!bit_tick && n < 100);
        check("tick_spacing", n, 32'd50);

        // Good packet, length 2
        start_pkt(8'd2, sw);
        run_pkt(8'd2);
        check("p2_valid_count", n_valid, 32'd56);
        check("p2_done", done_cnt, 32'd1);
        check("p2_err", err_cnt, 32'd0);
        check("p2_seed_cnt", seed_cnt, 32'd1);
        check("p2_pkt_len", 32'(pkt_len), 32'd2);
        check("p2_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("seed_literal", 32'(dw_seed_load), 32'd0);

        // Over-length header
        start_pkt(8'd40, sw);
        run_pkt(8'd40);
        check("p40_valid_count", n_valid, 32'd16);
        check("p40_err", err_cnt, 32'd1);
        check("p40_done", done_cnt, 32'd0);
        check("p40_pkt_len", 32'(pkt_len), 32'd40);
        cyc();
        check("p40_back_to_hunt", 32'({busy, dw_trigger}), 32'd0);

        // Good packet after the error, length 5
        start_pkt(8'd5, sw);
        run_pkt(8'd5);
        check("p5_valid_count", n_valid, 32'd80);
        check("p5_done", done_cnt, 32'd1);
        check("p5_err", err_cnt, 32'd0);

        // Zero-length payload still carries the CRC
        start_pkt(8'd0, sw);
        run_pkt(8'd0);
        check("p0_valid_count", n_valid, 32'd40);
        check("p0_done", done_cnt, 32'd1);
        check("p0_pkt_len", 32'(pkt_len), 32'd0);

        // Abort during payload bit 10
        start_pkt(8'd4, sw);
        n = 0;
        do begin cyc(); n++; end while (n_valid < 26 && n < 8000);
        check("abort_reached_bit10", n_valid, 32'd26);
        enable = 1'b0;
        cyc();
        check("abort_idle", 32'({busy, dw_trigger}), 32'd0);
        for (int i = 0; i < 300; i++) cyc();
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_no_err", err_cnt, 32'd0);
        check("abort_no_more_pdu", n_valid, 32'd26);
        check("abort_len_kept", 32'(pkt_len), 32'd4);
        exp_q.delete(); tx_q.delete(); raw_q.delete();
        enable = 1'b1;

        // Corrupted sync word must never start a packet
        start_pkt(8'd1, sw ^ 32'h0000_0020);
        for (int i = 0; i < 80 * 50; i++) cyc();
        check("badsync_no_seed", seed_cnt, 32'd0);
        check("badsync_no_trig", trig_seen, 32'd0);
        check("badsync_no_pdu", n_valid, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
